bch_ecc_stream_seq: RTL and testbench
=====================================

Name: bch_ecc_stream_seq

Overview:
- Frame sequencer for the encode output path.
- Accepts DATA_WORDS data beats, passes them through to the output, then emits ECC_WORDS parity beats. Each parity beat is the encoder's ECC word XORed with the erased-flash pattern word from the blank-ECC block.
- Generates the start/ce/first strobes that drive the encoder input, the encoder ECC output and the blank-ECC XOR generator, so all three stay word-aligned under output back-pressure.

Parameters:
- DATA_BITS, 64: data bits per frame (>=1).
- ECC_BITS, 24: ECC bits per frame (>=1).
- BITS, 8: word width (>=1).
- Derived: DATA_WORDS = ceil(DATA_BITS/BITS), ECC_WORDS = ceil(ECC_BITS/BITS).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  BITS  data word from source.
- in_valid  in  1  source has a word.
- in_ready  out  1  sequencer accepts in_data this cycle.
- blank_en  in  1  sampled with first data beat; 1 = apply erased-ECC XOR for this frame.
- enc_start  out  1  encoder first-data-word strobe.
- enc_ce  out  1  encoder data-word accept strobe.
- ecc_in  in  BITS  current ECC word from encoder.
- xor_in  in  BITS  current word from blank-ECC generator.
- ecc_start  out  1  first-ECC-cycle strobe to encoder output and blank-ECC generator.
- ecc_ce  out  1  ECC word consumed; advance encoder output and blank-ECC generator.
- out_data  out  BITS  output word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- out_first  out  1  first word of frame.
- out_last  out  1  last word of frame.
- busy  out  1  frame in progress (state != IDLE).

Behaviour:
- Handshake:
  - beat_in = in_valid & in_ready.
  - beat_out = out_valid & out_ready.
  - No combinational path from out_valid to out_ready.
- State machine: IDLE, DATA, ECC.
  - Data counter dcnt: 0..DATA_WORDS-1.
  - ECC counter ecnt: 0..ECC_WORDS-1.
  - Frame flag blank_q.
- Reset: state=IDLE, dcnt=0, ecnt=0, blank_q=0.
  - Every output is 0 in the reset cycle and after it, except in_ready, which follows out_ready in IDLE.
  - Reset mid-frame abandons the frame: no further beats, no ecc_start.
- IDLE:
  - in_ready=out_ready; out_valid=in_valid; out_data=in_data; out_first=1.
  - enc_start=enc_ce=beat_in.
  - On beat_in: blank_q<=blank_en.
    - If DATA_WORDS==1: go to ECC, ecnt<=0.
    - Else: go to DATA, dcnt<=1.
- DATA:
  - in_ready=out_ready; out_valid=in_valid; out_data=in_data; enc_ce=beat_in; enc_start=0; out_first=0.
  - On beat_in: dcnt++.
  - If dcnt==DATA_WORDS-1: go to ECC, ecnt<=0.
- ECC:
  - in_ready=0; out_valid=1; out_first=0.
  - out_data = ecc_in ^ (blank_q ? xor_in : 0).
  - ecc_start = (ecnt==0), held until that word is accepted.
  - ecc_ce = out_ready.
  - out_last = (ecnt==ECC_WORDS-1).
  - On beat_out: ecnt++. If last: go to IDLE, dcnt<=0.
- Latency: data path is zero-cycle combinational pass-through. The first ECC word is presented the cycle after the last data beat.
- Back-pressure: out_ready low freezes all counters. ecc_start/ecc_ce remain level-consistent, so downstream pipelines advance only on beat_out.
- Back-to-back frames: the cycle after the last ECC beat, IDLE accepts a new first word. There are no dead cycles between frames beyond that.
- Single-word frame (DATA_WORDS==1): out_first and enc_start are on the same beat, followed directly by ECC.
- Single-ECC-word (ECC_WORDS==1): ecc_start and out_last are asserted on the same beat.
- blank_en changes mid-frame are ignored; only the value captured on the first data beat applies.
- Partial last words (DATA_BITS or ECC_BITS not a multiple of BITS) pass through unmodified. Padding is the producer's responsibility.

Test Plan:
- DATA_BITS=16, ECC_BITS=10, BITS=4, out_ready=1, blank_en=1, data 0xA,0xB,0xC,0xD; ecc_in 0x3,0x5,0x1; xor_in 0xF,0xF,0xC.
  - out: A,B,C,D,C,A,D.
  - out_first on beat 0; out_last on beat 6.
  - ecc_start on beat 4 only; ecc_ce on beats 4-6.
- Same stimulus with blank_en=0 -> ECC beats 3,5,1.
- Toggle out_ready 1-0-1 every cycle through ECC phase.
  - Each ECC word is held stable while out_ready=0.
  - ecc_start stays high until the first ECC word is accepted.
  - Exactly 3 ecc_ce pulses.
- Two frames back-to-back with in_valid held high.
  - Second frame's out_first appears the cycle after the first frame's out_last.
  - 14 total beats in 14 cycles.
- Assert reset during DATA with dcnt=2 -> next cycle busy=0, out_valid=in_valid; a new frame starts cleanly at dcnt=0 with enc_start.
- DATA_BITS=4, ECC_BITS=4, BITS=4 -> out_first+enc_start on beat 0; ecc_start+out_last on beat 1.

Source files
------------

// File: rtl/bch_ecc_stream_seq.sv
// Frame sequencer for the BCH encode output path: passes data words through, then
// emits ECC words (optionally XORed with the erased-flash pattern) with aligned strobes.
module bch_ecc_stream_seq #(
    parameter int DATA_BITS = 64,
    parameter int ECC_BITS  = 24,
    parameter int BITS      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            blank_en,
    output logic            enc_start,
    output logic            enc_ce,
    input  logic [BITS-1:0] ecc_in,
    input  logic [BITS-1:0] xor_in,
    output logic            ecc_start,
    output logic            ecc_ce,
    output logic [BITS-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_first,
    output logic            out_last,
    output logic            busy
);

    localparam int DATA_WORDS = (DATA_BITS + BITS - 1) / BITS;
    localparam int ECC_WORDS  = (ECC_BITS + BITS - 1) / BITS;
    localparam int DCW        = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam int ECW        = (ECC_WORDS > 1) ? $clog2(ECC_WORDS) : 1;

    localparam logic [DCW-1:0] DCNT_LAST = DCW'(DATA_WORDS - 1);
    localparam logic [ECW-1:0] ECNT_LAST = ECW'(ECC_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ECC  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [ECW-1:0] ecnt_q, ecnt_d;
    logic           blank_q, blank_d;

    logic beat_in;
    logic beat_out;

    // Outputs are decoded from state and live inputs so the data path stays
    // zero-latency; in_ready depends only on out_ready and state, never on out_valid.
    always_comb begin : out_logic
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_first = 1'b0;
        out_last  = 1'b0;
        enc_start = 1'b0;
        enc_ce    = 1'b0;
        ecc_start = 1'b0;
        ecc_ce    = 1'b0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                out_data  = in_data;
                // first-word flag only carries meaning alongside a presented word
                out_first = in_valid;
                enc_start = in_valid & out_ready;
                enc_ce    = in_valid & out_ready;
            end
            ST_DATA: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                out_data  = in_data;
                enc_ce    = in_valid & out_ready;
            end
            ST_ECC: begin
                out_valid = 1'b1;
                out_data  = ecc_in ^ (blank_q ? xor_in : '0);
                ecc_start = (ecnt_q == '0);
                ecc_ce    = out_ready;
                out_last  = (ecnt_q == ECNT_LAST);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        if (reset) begin
            in_ready  = out_ready;
            out_valid = 1'b0;
            out_data  = '0;
            out_first = 1'b0;
            out_last  = 1'b0;
            enc_start = 1'b0;
            enc_ce    = 1'b0;
            ecc_start = 1'b0;
            ecc_ce    = 1'b0;
            busy      = 1'b0;
        end
    end

    assign beat_in  = in_valid & in_ready;
    assign beat_out = out_valid & out_ready;

    always_comb begin : next_state
        state_d = state_q;
        dcnt_d  = dcnt_q;
        ecnt_d  = ecnt_q;
        blank_d = blank_q;
        case (state_q)
            ST_IDLE: begin
                if (beat_in) begin
                    blank_d = blank_en;
                    if (DATA_WORDS == 1) begin
                        state_d = ST_ECC;
                        ecnt_d  = '0;
                    end else begin
                        state_d = ST_DATA;
                        dcnt_d  = DCW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (beat_in) begin
                    if (dcnt_q == DCNT_LAST) begin
                        state_d = ST_ECC;
                        ecnt_d  = '0;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + DCW'(1);
                    end
                end
            end
            ST_ECC: begin
                if (beat_out) begin
                    if (ecnt_q == ECNT_LAST) begin
                        state_d = ST_IDLE;
                        dcnt_d  = '0;
                        ecnt_d  = '0;
                    end else begin
                        ecnt_d = ecnt_q + ECW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                dcnt_d  = '0;
                ecnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dcnt_q  <= '0;
            ecnt_q  <= '0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            ecnt_q  <= ecnt_d;
            blank_q <= blank_d;
        end
    end

endmodule

// File: tb/tb_bch_ecc_stream_seq.sv
// Bench for bch_ecc_stream_seq: a 4-data/3-ECC word instance checked beat by beat
// against a frame model, plus a 1-data/1-ECC word instance checked directly.
module tb_bch_ecc_stream_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 1: 16 data bits, 10 ECC bits, 4-bit words ----------------
    logic [3:0] in_data, ecc_in, xor_in, out_data;
    logic in_valid, in_ready, blank_en, enc_start, enc_ce, ecc_start, ecc_ce;
    logic out_valid, out_ready, out_first, out_last, busy;

    bch_ecc_stream_seq #(.DATA_BITS(16), .ECC_BITS(10), .BITS(4)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .blank_en(blank_en), .enc_start(enc_start),
        .enc_ce(enc_ce), .ecc_in(ecc_in), .xor_in(xor_in), .ecc_start(ecc_start),
        .ecc_ce(ecc_ce), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_first(out_first), .out_last(out_last), .busy(busy)
    );

    // ---------------- DUT 2: single data word, single ECC word ----------------
    logic [3:0] in_data2, ecc_in2, xor_in2, out_data2;
    logic in_valid2, in_ready2, blank_en2, enc_start2, enc_ce2, ecc_start2, ecc_ce2;
    logic out_valid2, out_ready2, out_first2, out_last2, busy2;

    bch_ecc_stream_seq #(.DATA_BITS(4), .ECC_BITS(4), .BITS(4)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .blank_en(blank_en2), .enc_start(enc_start2),
        .enc_ce(enc_ce2), .ecc_in(ecc_in2), .xor_in(xor_in2), .ecc_start(ecc_start2),
        .ecc_ce(ecc_ce2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_first(out_first2), .out_last(out_last2), .busy(busy2)
    );

    // ---------------- encoder / blank-ECC stand-ins for DUT 1 ----------------
    logic [3:0] ecc_tab [4] = '{4'h3, 4'h5, 4'h1, 4'h0};
    logic [3:0] xor_tab [4] = '{4'hF, 4'hF, 4'hC, 4'h0};
    logic [1:0] eidx;
    always @(posedge clk) begin
        if (reset)                       eidx <= 2'd0;
        else if (enc_start)              eidx <= 2'd0;
        else if (ecc_ce && eidx != 2'd3) eidx <= eidx + 2'd1;
    end
    assign ecc_in = ecc_tab[eidx];
    assign xor_in = xor_tab[eidx];

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // beat vector: {data, first, last, ecc_start, ecc_ce, enc_start, enc_ce}
    function automatic logic [9:0] mk(input logic [3:0] d, input logic f, input logic l,
                                      input logic es, input logic ece,
                                      input logic encs, input logic ence);
        return {d, f, l, es, ece, encs, ence};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [9:0] exp_q[$];
    logic [9:0] log_q[$];
    int         log_cyc[$];
    int         ecc_ce_cnt = 0;
    logic       prev_hold  = 1'b0;
    logic [5:0] prev_word;
    logic [9:0] act;

    always @(negedge clk) begin
        #1;
        act = {out_data, out_first, out_last, ecc_start, ecc_ce, enc_start, enc_ce};
        if (reset) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_word", 32'({out_data, out_last, ecc_start}), 32'(prev_word));
            end
            if (ecc_ce) begin
                ecc_ce_cnt++;
                chk("ecc_ce_with_ready", 32'(out_ready), 32'd1);
            end
            if (out_valid && out_ready) begin
                log_q.push_back(act);
                log_cyc.push_back(cyc);
                chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("beat", 32'(act), 32'(exp_q.pop_front()));
            end
            prev_hold = out_valid && !out_ready;
            prev_word = {out_data, out_last, ecc_start};
        end
    end

    // out_ready toggles every cycle while tmode is set
    logic tmode = 1'b0;
    always @(posedge clk) begin
        #1;
        if (tmode) out_ready = ~out_ready;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_word(input logic [3:0] w, input logic be, input logic first);
        logic got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        blank_en = be;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            if (got) exp_q.push_back(mk(w, first, 1'b0, 1'b0, 1'b0, first, 1'b1));
            @(posedge clk);
            #1;
        end
        chk("in_accept", 32'(got), 32'd1);
    endtask

    // blank_en is inverted after the first word; only the first value may count
    task automatic send_frame(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3, input logic blank);
        logic [3:0] w [4];
        w[0] = d0; w[1] = d1; w[2] = d2; w[3] = d3;
        for (int k = 0; k < 4; k++) drive_word(w[k], (k == 0) ? blank : ~blank, k == 0);
        for (int k = 0; k < 3; k++)
            exp_q.push_back(mk(ecc_tab[2'(k)] ^ (blank ? xor_tab[2'(k)] : 4'h0),
                               1'b0, k == 2, k == 0, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int t = 0; t < 100 && !idle; t++) begin
            @(negedge clk);
            #2;
            idle = !busy;
        end
        chk("frame_done", 32'(idle), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500000");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    logic [3:0] t1_lit [7] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hC, 4'hA, 4'hD};
    logic [3:0] t2_lit [3] = '{4'h3, 4'h5, 4'h1};
    int base;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 4'h0; blank_en = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = 4'h0; blank_en2 = 1'b0; out_ready2 = 1'b1;
        ecc_in2 = 4'h6; xor_in2 = 4'h9;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", 32'({out_first, out_last, enc_start, enc_ce, ecc_start, ecc_ce}), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst2_out_valid", 32'(out_valid2), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #2;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_strobes", 32'({out_first, out_last, enc_start, enc_ce, ecc_start, ecc_ce, busy}), 32'd0);
        @(posedge clk); #1;

        // frame with erased-ECC XOR applied
        log_q.delete(); log_cyc.delete();
        send_frame(4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
        in_valid = 1'b0;
        wait_idle();
        chk("t1_beats", 32'(log_q.size()), 32'd7);
        for (int k = 0; k < 7; k++) begin
            if (k < log_q.size()) begin
                chk("t1_data", 32'(log_q[k][9:6]), 32'(t1_lit[k]));
                chk("t1_flags", 32'(log_q[k][5:2]), 32'({k == 0, k == 6, k == 4, k >= 4}));
            end
        end
        chk("t1_drained", 32'(exp_q.size()), 32'd0);

        // same frame without the XOR
        log_q.delete(); log_cyc.delete();
        send_frame(4'hA, 4'hB, 4'hC, 4'hD, 1'b0);
        in_valid = 1'b0;
        wait_idle();
        chk("t2_beats", 32'(log_q.size()), 32'd7);
        for (int k = 0; k < 3; k++)
            if (k + 4 < log_q.size()) chk("t2_ecc", 32'(log_q[k + 4][9:6]), 32'(t2_lit[k]));

        // out_ready toggling every cycle
        base  = ecc_ce_cnt;
        tmode = 1'b1;
        send_frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        in_valid = 1'b0;
        wait_idle();
        #1;
        tmode = 1'b0;
        out_ready = 1'b1;
        chk("t3_ecc_ce_pulses", 32'(ecc_ce_cnt - base), 32'd3);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // back-to-back frames, in_valid never drops
        @(posedge clk); #1;
        log_q.delete(); log_cyc.delete();
        send_frame(4'h5, 4'h6, 4'h7, 4'h8, 1'b1);
        send_frame(4'h9, 4'hA, 4'hB, 4'hC, 1'b0);
        in_valid = 1'b0;
        wait_idle();
        chk("t4_beats", 32'(log_q.size()), 32'd14);
        if (log_q.size() == 14) begin
            chk("t4_span", 32'(log_cyc[13] - log_cyc[0]), 32'd13);
            chk("t4_gap", 32'(log_cyc[7] - log_cyc[6]), 32'd1);
            chk("t4_last_then_first", 32'({log_q[6][4], log_q[7][5]}), 32'b11);
        end

        // reset in the middle of DATA after two beats
        drive_word(4'h1, 1'b0, 1'b1);
        drive_word(4'h2, 1'b1, 1'b0);
        reset = 1'b1; in_valid = 1'b1; in_data = 4'h3;
        @(negedge clk); #2;
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_strobes", 32'({enc_start, enc_ce, ecc_start, ecc_ce, busy}), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b0;
        @(negedge clk); #2;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd1);
        chk("t5_first_no_start", 32'({out_first, enc_start, in_ready}), 32'b100);
        @(posedge clk); #1;
        out_ready = 1'b1;
        log_q.delete(); log_cyc.delete();
        send_frame(4'h3, 4'h4, 4'h5, 4'h6, 1'b1);
        in_valid = 1'b0;
        wait_idle();
        chk("t5_beats", 32'(log_q.size()), 32'd7);
        if (log_q.size() > 0) chk("t5_restart", 32'({log_q[0][9:6], log_q[0][1]}), 32'({4'h3, 1'b1}));
        chk("t5_drained", 32'(exp_q.size()), 32'd0);

        // single data word, single ECC word
        in_valid2 = 1'b1; in_data2 = 4'h7; blank_en2 = 1'b1;
        @(negedge clk); #2;
        chk("t6_beat0_data", 32'(out_data2), 32'h7);
        chk("t6_beat0_flags", 32'({out_valid2, out_first2, enc_start2, enc_ce2, out_last2, ecc_start2}), 32'b111100);
        @(posedge clk); #1;
        in_valid2 = 1'b0; blank_en2 = 1'b0;
        @(negedge clk); #2;
        chk("t6_beat1_data", 32'(out_data2), 32'hF);
        chk("t6_beat1_flags", 32'({out_valid2, ecc_start2, out_last2, ecc_ce2, in_ready2, out_first2}), 32'b111100);
        @(posedge clk); #1;
        in_valid2 = 1'b1; in_data2 = 4'h2; blank_en2 = 1'b0;
        @(negedge clk); #2;
        chk("t6_idle_again", 32'({busy2, out_first2, enc_start2}), 32'b011);
        @(posedge clk); #1;
        in_valid2 = 1'b0; blank_en2 = 1'b1;
        @(negedge clk); #2;
        chk("t6_noblank_data", 32'(out_data2), 32'h6);
        chk("t6_noblank_flags", 32'({ecc_start2, out_last2}), 32'b11);
        @(posedge clk); #1;
        @(negedge clk); #2;
        chk("t6_done", 32'({busy2, out_valid2}), 32'b00);

        chk("final_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
